cir_avg_sched: RTL and testbench
================================

Name: cir_avg_sched

Overview:
Sequencing controller placed in front of the HLS CIR averaging core inside the CIR averaging noc_block.
- Latches the runtime configuration (threshold, log2 average size, sequence length) and applies it to the core only at averaging-window boundaries.
- Pulses the core reset whenever the configuration changes, then re-frames the sample stream into packets of exactly seq_len samples.
- Counts samples, packets, windows and completed output packets for readback.

Parameters:
RST_CYCLES, 4, cycles core_rst_n is held low per core reset (>=1)
CNT_W, 16, width of the readback packet counters

Ports:
ap_clk  in  1  block clock
ap_rst_n  in  1  synchronous active-low reset
cfg_stb  in  1  one-cycle strobe: new cfg_* values valid
cfg_threshold  in  32  requested threshold
cfg_log_avg  in  3  requested log2(average size)
cfg_seq_len  in  10  requested sequence length; 0 = disabled
s_tdata  in  32  sample from the AXI wrapper
s_tvalid  in  1  sample valid
s_tready  out  1  sample accept
s_tlast  in  1  upstream packet end (checked only, never forwarded)
m_tdata  out  32  sample to the core
m_tvalid  out  1  valid to the core
m_tready  in  1  core ready
m_tlast  out  1  regenerated end of sequence
core_rst_n  out  1  core reset (active-low)
threshold_V  out  32  applied threshold
log_avg_size_V  out  3  applied log2 average size
seq_len_V  out  10  applied sequence length
mon_tvalid  in  1  core output valid (monitor)
mon_tready  in  1  core output ready (monitor)
mon_tlast  in  1  core output last (monitor)
busy  out  1  FSM not in IDLE
err_len  out  1  sticky: s_tlast disagreed with regenerated framing
win_cnt  out  CNT_W  completed input windows
out_pkt_cnt  out  CNT_W  completed core output packets

Behaviour:
- Reset (ap_rst_n low at a clock edge) puts every output at these values:
  - FSM = IDLE, core_rst_n = 0
  - applied cfg = 0, pend = 0
  - all counters = 0, err_len = 0, busy = 0
  - s_tready = 0, m_tvalid = 0, m_tlast = 0
- Datapath is combinational pass-through:
  - m_tdata = s_tdata
  - m_tvalid = s_tvalid & run
  - s_tready = m_tready & run
  - m_tlast = (smp_cnt == seq_len_V-1) & run
  - run = (state == RUN); zero added latency.
- Beat = s_tvalid & s_tready.
  - smp_cnt (10b) increments per beat and wraps to 0 on the m_tlast beat.
  - On that wrap, pkt_cnt (7b) increments. At pkt_cnt == 2^log_avg_size_V - 1 it wraps to 0 and win_cnt increments, saturating at all-ones.
- cfg_stb latches the cfg_* fields into a shadow register and sets pend. A second strobe overwrites the shadow; only the latest values are used.
- FSM:
  - IDLE: if pend and shadow seq_len != 0 -> APPLY. If pend and shadow seq_len == 0 -> clear pend, stay IDLE, core_rst_n = 0.
  - APPLY (1 cycle): copy shadow to the applied outputs, clear pend, zero smp_cnt/pkt_cnt, load the reset timer with RST_CYCLES -> RESET.
  - RESET: core_rst_n = 0 while the timer counts down; at 0 -> RUN.
  - RUN: core_rst_n = 1. If pend, a beat that completes a window (last sample of the last packet) -> APPLY on the next cycle. If pend with shadow seq_len == 0, the same boundary -> IDLE.
- A cfg_stb in the same cycle as a window-completing beat is held in pend; it is not applied at that boundary and waits for the next one.
- Core reset is never asserted mid-window; a pending config waits for the window to complete.
- err_len sets on a beat where s_tlast != m_tlast. It clears only on ap_rst_n. Framing is not realigned.
- out_pkt_cnt increments (saturating) on each mon_tvalid & mon_tready & mon_tlast, in any state.
- ap_rst_n low mid-packet: all state clears and the partial packet is dropped. The core is held in reset by core_rst_n = 0.

Decomposition:
- Shared package cir_avg_pkg: FSM state encoding (IDLE, APPLY, RESET, RUN), the seq_len/log_avg/threshold widths, and the readback address map.
- One natural sub-module: cir_avg_frame_cnt, the smp_cnt/pkt_cnt/window-done counter pair, reused by the output-side checker.

Test Plan:
- Reset, then cfg_stb (seq_len=4, log_avg=1, thr=100) -> core_rst_n low exactly 4 cycles, applied cfg visible; 8 samples streamed -> m_tlast on beats 4 and 8, win_cnt=1.
- cfg_stb mid-window (after sample 3 of 8) with seq_len=6 -> seq_len_V stays 4 through beat 8, changes the cycle after, core_rst_n pulses, then m_tlast every 6 beats.
- m_tready toggled 1/0 every cycle with s_tvalid held high -> no beat lost or duplicated; smp_cnt advances only on handshakes; m_tlast aligned to beat 4.
- s_tlast asserted on beat 3 with seq_len=4 -> err_len=1 and stays 1; m_tlast still on beat 4.
- cfg_stb with seq_len=0 during RUN -> returns to IDLE at the window end, s_tready=0, core_rst_n=0, busy=0.
- ap_rst_n low for 1 cycle mid-packet -> all counters 0, m_tvalid=0, FSM IDLE; a new cfg is needed to resume.

Source files
------------

// File: rtl/cir_avg_pkg.sv
// rtl/cir_avg_pkg.sv - shared types, widths and readback map for the CIR averaging sequencer
package cir_avg_pkg;

    localparam int THR_W     = 32;
    localparam int LOG_AVG_W = 3;
    localparam int SEQ_LEN_W = 10;
    localparam int PKT_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_RESET,
        ST_RUN
    } state_t;

    // Readback register byte addresses
    localparam logic [7:0] ADDR_THRESHOLD   = 8'h00;
    localparam logic [7:0] ADDR_LOG_AVG     = 8'h04;
    localparam logic [7:0] ADDR_SEQ_LEN     = 8'h08;
    localparam logic [7:0] ADDR_WIN_CNT     = 8'h0C;
    localparam logic [7:0] ADDR_OUT_PKT_CNT = 8'h10;
    localparam logic [7:0] ADDR_STATUS      = 8'h14;

    // Index of the last packet in a window: 2^log_avg - 1
    function automatic logic [PKT_CNT_W-1:0] pkt_max(input logic [LOG_AVG_W-1:0] log_avg);
        logic [PKT_CNT_W:0] one_hot;
        logic [PKT_CNT_W:0] full;
        one_hot          = '0;
        one_hot[log_avg] = 1'b1;
        full             = one_hot - (PKT_CNT_W+1)'(1);
        return full[PKT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/cir_avg_frame_cnt.sv
// rtl/cir_avg_frame_cnt.sv - sample/packet counter pair that regenerates sequence framing
//
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   clr             zero both counters (new configuration)
//   beat            one accepted sample
//   seq_len         samples per packet (non-zero while counting)
//   log_avg         log2 of packets per window
//   last            current sample is the last of its packet
//   win_done        this beat completes a window
module cir_avg_frame_cnt
    import cir_avg_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 beat,
    input  logic [SEQ_LEN_W-1:0] seq_len,
    input  logic [LOG_AVG_W-1:0] log_avg,
    output logic                 last,
    output logic                 win_done
);

    logic [SEQ_LEN_W-1:0] smp_cnt;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic                 pkt_last;

    assign last     = (smp_cnt == seq_len - SEQ_LEN_W'(1));
    assign pkt_last = (pkt_cnt == pkt_max(log_avg));
    assign win_done = beat & last & pkt_last;

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            smp_cnt <= '0;
            pkt_cnt <= '0;
        end else if (beat) begin
            if (last) begin
                smp_cnt <= '0;
                pkt_cnt <= pkt_last ? '0 : pkt_cnt + PKT_CNT_W'(1);
            end else begin
                smp_cnt <= smp_cnt + SEQ_LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/cir_avg_sched.sv
// rtl/cir_avg_sched.sv - applies CIR averaging config at window boundaries and re-frames the sample stream
//
// Ports:
//   ap_clk, ap_rst_n                  clock, synchronous active-low reset
//   cfg_stb, cfg_*                    runtime configuration request
//   s_tdata/s_tvalid/s_tready/s_tlast sample input (s_tlast only checked)
//   m_tdata/m_tvalid/m_tready/m_tlast sample output to the core, regenerated framing
//   core_rst_n                        core reset, active-low
//   threshold_V, log_avg_size_V, seq_len_V  applied configuration
//   mon_tvalid/mon_tready/mon_tlast   core output handshake monitor
//   busy, err_len, win_cnt, out_pkt_cnt     status and counters
module cir_avg_sched
    import cir_avg_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 cfg_stb,
    input  logic [THR_W-1:0]     cfg_threshold,
    input  logic [LOG_AVG_W-1:0] cfg_log_avg,
    input  logic [SEQ_LEN_W-1:0] cfg_seq_len,
    input  logic [31:0]          s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 core_rst_n,
    output logic [THR_W-1:0]     threshold_V,
    output logic [LOG_AVG_W-1:0] log_avg_size_V,
    output logic [SEQ_LEN_W-1:0] seq_len_V,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic                 mon_tlast,
    output logic                 busy,
    output logic                 err_len,
    output logic [CNT_W-1:0]     win_cnt,
    output logic [CNT_W-1:0]     out_pkt_cnt
);

    localparam int TMR_W = $clog2(RST_CYCLES + 1);

    state_t               state;
    logic [THR_W-1:0]     sh_thr;
    logic [LOG_AVG_W-1:0] sh_log;
    logic [SEQ_LEN_W-1:0] sh_seq;
    logic                 pend;
    logic [TMR_W-1:0]     timer;
    logic                 run;
    logic                 beat;
    logic                 last;
    logic                 win_done;

    assign run      = (state == ST_RUN);
    assign busy     = (state != ST_IDLE);
    assign m_tdata  = s_tdata;
    assign m_tvalid = s_tvalid & run;
    assign s_tready = m_tready & run;
    assign m_tlast  = last & run;
    assign beat     = s_tvalid & s_tready;

    cir_avg_frame_cnt u_frame (
        .clk      (ap_clk),
        .resetn   (ap_rst_n),
        .clr      (state == ST_APPLY),
        .beat     (beat),
        .seq_len  (seq_len_V),
        .log_avg  (log_avg_size_V),
        .last     (last),
        .win_done (win_done)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state          <= ST_IDLE;
            core_rst_n     <= 1'b0;
            threshold_V    <= '0;
            log_avg_size_V <= '0;
            seq_len_V      <= '0;
            sh_thr         <= '0;
            sh_log         <= '0;
            sh_seq         <= '0;
            pend           <= 1'b0;
            timer          <= '0;
            err_len        <= 1'b0;
            win_cnt        <= '0;
            out_pkt_cnt    <= '0;
        end else begin
            if (mon_tvalid && mon_tready && mon_tlast && out_pkt_cnt != '1)
                out_pkt_cnt <= out_pkt_cnt + CNT_W'(1);
            if (win_done && win_cnt != '1)
                win_cnt <= win_cnt + CNT_W'(1);
            if (beat && (s_tlast != m_tlast))
                err_len <= 1'b1;

            // Applied config is loaded on the edge that leaves IDLE/RUN so it
            // is already visible during the APPLY cycle; pend clears on that
            // same edge so a strobe arriving then survives for the next window.
            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        if (sh_seq != '0) begin
                            state          <= ST_APPLY;
                            threshold_V    <= sh_thr;
                            log_avg_size_V <= sh_log;
                            seq_len_V      <= sh_seq;
                        end
                    end
                end
                ST_APPLY: begin
                    timer      <= TMR_W'(RST_CYCLES);
                    core_rst_n <= 1'b0;
                    state      <= ST_RESET;
                end
                ST_RESET: begin
                    if (timer == TMR_W'(1)) begin
                        core_rst_n <= 1'b1;
                        state      <= ST_RUN;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (pend && win_done) begin
                        pend <= 1'b0;
                        if (sh_seq != '0) begin
                            state          <= ST_APPLY;
                            threshold_V    <= sh_thr;
                            log_avg_size_V <= sh_log;
                            seq_len_V      <= sh_seq;
                        end else begin
                            state      <= ST_IDLE;
                            core_rst_n <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A new strobe always wins over the pend clear above
            if (cfg_stb) begin
                sh_thr <= cfg_threshold;
                sh_log <= cfg_log_avg;
                sh_seq <= cfg_seq_len;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cir_avg_sched.sv
// tb/tb_cir_avg_sched.sv - scoreboard bench for cir_avg_sched
module tb_cir_avg_sched;

    localparam int RST_CYCLES = 4;
    localparam int CNT_W      = 16;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        cfg_stb;
    logic [31:0] cfg_threshold;
    logic [2:0]  cfg_log_avg;
    logic [9:0]  cfg_seq_len;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        core_rst_n;
    logic [31:0] threshold_V;
    logic [2:0]  log_avg_size_V;
    logic [9:0]  seq_len_V;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic        busy;
    logic        err_len;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] out_pkt_cnt;

    always #5 ap_clk = ~ap_clk;

    cir_avg_sched #(.RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .cfg_stb        (cfg_stb),
        .cfg_threshold  (cfg_threshold),
        .cfg_log_avg    (cfg_log_avg),
        .cfg_seq_len    (cfg_seq_len),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .core_rst_n     (core_rst_n),
        .threshold_V    (threshold_V),
        .log_avg_size_V (log_avg_size_V),
        .seq_len_V      (seq_len_V),
        .mon_tvalid     (mon_tvalid),
        .mon_tready     (mon_tready),
        .mon_tlast      (mon_tlast),
        .busy           (busy),
        .err_len        (err_len),
        .win_cnt        (win_cnt),
        .out_pkt_cnt    (out_pkt_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   toggle_en   = 1'b0;

    // Scoreboard monitor: every beat into the core must match the next expected sample
    always @(negedge ap_clk) begin : mon_blk
        exp_t e;
        if (ap_rst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got data %08h last %0b, expected no beat", m_tdata, m_tlast);
            end else begin
                e = exp_q.pop_front();
                if (m_tdata !== e.data || m_tlast !== e.last) begin
                    miscompares++;
                    $display("FAIL beat: got data %08h last %0b, expected data %08h last %0b",
                             m_tdata, m_tlast, e.data, e.last);
                end
            end
        end
    end

    always begin
        @(posedge ap_clk);
        #1;
        if (toggle_en) m_tready = ~m_tready;
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [31:0] thr, input logic [2:0] la, input logic [9:0] sl);
        cfg_threshold = thr;
        cfg_log_avg   = la;
        cfg_seq_len   = sl;
        cfg_stb       = 1'b1;
        tick();
        cfg_stb       = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic exp_last, input logic s_last);
        bit got = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = s_last;
        exp_q.push_back(exp_t'{d, exp_last});
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            if (s_tready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge ap_clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no handshake for %08h, expected one", d);
        end
    endtask

    // Samples first..first+n-1 of a window; last whenever the index is a multiple of seq
    task automatic send_n(input logic [31:0] base, input int first, input int n, input int seq);
        for (int i = first; i < first + n; i++) begin
            send(base + 32'(i), (i % seq) == 0, (i % seq) == 0);
        end
    endtask

    // Counts cycles with core_rst_n low until it rises again
    task automatic wait_run(input string name, input int exp_low);
        int n = 0;
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (!core_rst_n) n++;
            else if (n > 0) begin
                done = 1'b1;
                break;
            end
        end
        tick();
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got core_rst_n stuck, expected release after %0d cycles", name, exp_low);
        end else begin
            check(name, n, exp_low);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n = 1'b0; cfg_stb = 1'b0; cfg_threshold = '0; cfg_log_avg = '0; cfg_seq_len = '0;
        s_tdata = 32'hDEAD_BEEF; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_win_cnt", win_cnt, 0);
        check("rst_out_pkt_cnt", out_pkt_cnt, 0);
        check("rst_err_len", err_len, 0);
        check("rst_seq_len_V", seq_len_V, 0);
        check("rst_threshold_V", threshold_V, 0);
        check("rst_log_avg_V", log_avg_size_V, 0);
        s_tvalid = 1'b0;
        ap_rst_n = 1'b1;

        // First configuration from IDLE: 1 pend + 1 apply + 4 reset cycles
        cfg(100, 1, 4);
        wait_run("t1_core_rst_cycles", 6);
        check("t1_threshold_V", threshold_V, 100);
        check("t1_log_avg_V", log_avg_size_V, 1);
        check("t1_seq_len_V", seq_len_V, 4);
        check("t1_busy", busy, 1);
        send_n(32'h1000, 1, 8, 4);
        check("t1_win_cnt", win_cnt, 1);

        // Mid-window reconfiguration waits for the window end
        send_n(32'h2000, 1, 3, 4);
        cfg(200, 1, 6);
        send_n(32'h2000, 4, 4, 4);
        check("t2_seq_len_before", seq_len_V, 4);
        send_n(32'h2000, 8, 1, 4);
        check("t2_seq_len_after", seq_len_V, 6);
        check("t2_threshold_after", threshold_V, 200);
        wait_run("t2_core_rst_pulse", 4);
        check("t2_win_cnt", win_cnt, 2);
        send_n(32'h3000, 1, 8, 6);
        cfg(300, 0, 4);
        send_n(32'h3000, 9, 4, 6);
        check("t2_win_cnt_seq6", win_cnt, 3);
        wait_run("t2b_core_rst_pulse", 4);
        check("t2b_seq_len_V", seq_len_V, 4);
        check("t2b_log_avg_V", log_avg_size_V, 0);

        // Backpressure: m_tready toggling every cycle
        toggle_en = 1'b1;
        send_n(32'h4000, 1, 8, 4);
        toggle_en = 1'b0;
        tick();
        m_tready = 1'b1;
        check("t3_win_cnt", win_cnt, 5);

        // Upstream framing disagreement
        check("t4_err_len_clean", err_len, 0);
        send(32'h5001, 1'b0, 1'b0);
        send(32'h5002, 1'b0, 1'b0);
        send(32'h5003, 1'b0, 1'b1);
        send(32'h5004, 1'b1, 1'b0);
        check("t4_err_len_set", err_len, 1);
        send_n(32'h5100, 1, 4, 4);
        check("t4_err_len_sticky", err_len, 1);
        check("t4_win_cnt", win_cnt, 7);

        // Output packet counter: only valid & ready & last counts
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
        tick(); tick();
        mon_tready = 1'b0; tick();
        mon_tready = 1'b1; mon_tlast = 1'b0; tick();
        mon_tlast = 1'b1; tick();
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        check("t4_out_pkt_cnt", out_pkt_cnt, 3);

        // seq_len = 0 request drops back to IDLE at window end
        cfg(0, 0, 0);
        send_n(32'h6000, 1, 4, 4);
        check("t5_busy", busy, 0);
        check("t5_s_tready", s_tready, 0);
        check("t5_core_rst_n", core_rst_n, 0);
        check("t5_win_cnt", win_cnt, 8);
        s_tvalid = 1'b1;
        tick();
        check("t5_m_tvalid", m_tvalid, 0);
        s_tvalid = 1'b0;

        // Reset mid-packet
        cfg(7, 1, 4);
        wait_run("t6_core_rst_cycles", 6);
        send_n(32'h7000, 1, 2, 4);
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        check("t6_win_cnt", win_cnt, 0);
        check("t6_out_pkt_cnt", out_pkt_cnt, 0);
        check("t6_err_len", err_len, 0);
        check("t6_busy", busy, 0);
        check("t6_seq_len_V", seq_len_V, 0);
        check("t6_core_rst_n", core_rst_n, 0);
        s_tvalid = 1'b1;
        s_tdata  = 32'h7777;
        tick();
        check("t6_m_tvalid", m_tvalid, 0);
        repeat (5) tick();
        check("t6_stays_idle", busy, 0);
        s_tvalid = 1'b0;
        cfg(8, 1, 4);
        wait_run("t6b_core_rst_cycles", 6);
        send_n(32'h8000, 1, 4, 4);
        check("t6b_win_cnt", win_cnt, 0);

        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
